// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared types, default sizes and helpers for the multi-port
//             register file with busy scoreboard and register-dump engine.
//  Contents : dump_state_t      - dump engine state encoding
//             c_DEF_*           - default width/count constants
//             bypass_sel()      - index of the highest-priority write hit
//  Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_RUN  = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

    localparam int c_DEF_DATA_WIDTH = 64;
    localparam int c_DEF_NUM_REGS   = 32;
    localparam int c_DEF_RD_PORTS   = 2;
    localparam int c_DEF_WR_PORTS   = 2;
    // Upper bound on write ports handled by the forwarding priority select.
    localparam int c_MAX_WR_PORTS   = 16;

    // Returns the highest set bit position of the hit vector, or -1 when no
    // write port targets the looked-up address. Later ports override earlier
    // ones, matching the write-commit priority.
    function automatic int bypass_sel(input logic [c_MAX_WR_PORTS-1:0] hits);
        int sel;
        sel = -1;
        for (int j = 0; j < c_MAX_WR_PORTS; j++) begin
            if (hits[j]) begin
                sel = j;
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_dump_fsm
//  Purpose  : Sequencer for the streaming register dump. Walks the register
//             index from 0 to NUM_REGS-1 under a valid/ready handshake and
//             pulses done for one cycle after the final beat is accepted.
//  Ports    : clk, reset    - clock, asynchronous active-high reset
//             i_start       - request a dump (honoured only when idle)
//             i_ready       - consumer accepts the current beat
//             o_valid       - beat valid
//             o_done        - one-cycle completion pulse
//             o_idx         - register index of the current beat
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = c_DEF_NUM_REGS,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_ready,
    output logic          o_valid,
    output logic          o_done,
    output logic [AW-1:0] o_idx
);

    localparam logic [AW-1:0] c_LAST = AW'(NUM_REGS - 1);

    dump_state_t   r_state;
    dump_state_t   w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DUMP_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        o_valid     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            DUMP_IDLE: begin
                if (i_start) begin
                    w_state_nxt = DUMP_RUN;
                    w_idx_nxt   = '0;
                end
            end
            DUMP_RUN: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    // Terminal compare stops the walk before idx could wrap.
                    if (r_idx == c_LAST) begin
                        w_state_nxt = DUMP_DONE;
                    end else begin
                        w_idx_nxt = r_idx + AW'(1);
                    end
                end
            end
            DUMP_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = DUMP_IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = DUMP_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp_sb
//  Purpose  : Parametrised multi-port integer register file with a per-register
//             busy scoreboard and a handshaked streaming register dump.
//             Register 0 reads as zero and ignores writes and allocations.
//  Ports    : clk, reset             - clock, asynchronous active-high reset
//             rd_addr/rd_data/rd_busy - combinational read ports (packed)
//             wr_en/wr_addr/wr_data   - write ports (packed), highest index wins
//             alloc_en/alloc_addr     - mark a destination register busy
//             dump_start/dump_ready   - dump request and beat acceptance
//             dump_valid/dump_idx/dump_data/dump_done - dump stream outputs
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int NUM_REGS       = c_DEF_NUM_REGS,
    parameter int NUM_RD_PORTS   = c_DEF_RD_PORTS,
    parameter int NUM_WR_PORTS   = c_DEF_WR_PORTS,
    parameter int BYPASS         = 1,
    localparam int AW            = $clog2(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_RD_PORTS*AW-1:0]             rd_addr,
    output logic [NUM_RD_PORTS*BUS_DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]                rd_busy,
    input  logic [NUM_WR_PORTS-1:0]                wr_en,
    input  logic [NUM_WR_PORTS*AW-1:0]             wr_addr,
    input  logic [NUM_WR_PORTS*BUS_DATA_WIDTH-1:0] wr_data,
    input  logic                                   alloc_en,
    input  logic [AW-1:0]                          alloc_addr,
    input  logic                                   dump_start,
    output logic                                   dump_valid,
    input  logic                                   dump_ready,
    output logic [AW-1:0]                          dump_idx,
    output logic [BUS_DATA_WIDTH-1:0]              dump_data,
    output logic                                   dump_done
);

    // One lookup per read port plus one for the dump stream.
    localparam int c_NUM_LOOKUPS = NUM_RD_PORTS + 1;

    logic [BUS_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]       r_busy;
    logic [AW-1:0]             w_dump_idx;

    // Ports are applied in ascending order so the highest-index port's
    // assignment is the one that lands. Allocation is applied last so a new
    // producer keeps the register busy even when a write retires it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
                    r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    r_busy[wr_addr[p*AW +: AW]] <= 1'b0;
                end
            end
            if (alloc_en && (alloc_addr != '0)) begin
                r_busy[alloc_addr] <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < c_NUM_LOOKUPS; g++) begin : g_lookup
            logic [AW-1:0]             w_addr;
            logic [c_MAX_WR_PORTS-1:0] w_hits;
            int                        w_sel;
            logic [BUS_DATA_WIDTH-1:0] w_data;

            if (g < NUM_RD_PORTS) begin : g_rd_port
                assign w_addr = rd_addr[g*AW +: AW];
                assign rd_data[g*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = w_data;
                // Register 0 is never set busy, so no special case is needed.
                assign rd_busy[g] = r_busy[w_addr];
            end else begin : g_dump_port
                assign w_addr    = w_dump_idx;
                assign dump_data = w_data;
            end

            // Register 0 holds zero permanently (reset to zero, writes dropped),
            // and is excluded from forwarding so it always reads as zero.
            always_comb begin
                w_hits = '0;
                w_sel  = -1;
                w_data = r_regs[w_addr];
                for (int p = 0; p < NUM_WR_PORTS; p++) begin
                    w_hits[p] = wr_en[p] && (wr_addr[p*AW +: AW] == w_addr) && (w_addr != '0);
                end
                if (BYPASS != 0) begin
                    w_sel = bypass_sel(w_hits);
                    for (int p = 0; p < NUM_WR_PORTS; p++) begin
                        if (p == w_sel) begin
                            w_data = wr_data[p*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                        end
                    end
                end
            end
        end
    endgenerate

    regfile_dump_fsm #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_dump_fsm (
        .clk     (clk),
        .reset   (reset),
        .i_start (dump_start),
        .i_ready (dump_ready),
        .o_valid (dump_valid),
        .o_done  (dump_done),
        .o_idx   (w_dump_idx)
    );

    assign dump_idx = w_dump_idx;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_regfile_mp_sb
//  Purpose  : Self-checking bench for regfile_mp_sb. Two instances share the
//             stimulus: one with forwarding, one without. A reference model of
//             the register file, scoreboard and dump sequence produces the
//             expected per-cycle outputs and accepted dump beats.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    localparam int DW  = 64;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*DW-1:0]  rd_data, rd_data_nb;
    logic [NRD-1:0]     rd_busy, rd_busy_nb;
    logic [NWR-1:0]     wr_en;
    logic [NWR*AW-1:0]  wr_addr;
    logic [NWR*DW-1:0]  wr_data;
    logic               alloc_en;
    logic [AW-1:0]      alloc_addr;
    logic               dump_start, dump_ready;
    logic               dump_valid, dump_done, dump_valid_nb, dump_done_nb;
    logic [AW-1:0]      dump_idx, dump_idx_nb;
    logic [DW-1:0]      dump_data, dump_data_nb;

    always #5 clk = ~clk;

    regfile_mp_sb #(.BUS_DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NRD),
                    .NUM_WR_PORTS(NWR), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done));

    regfile_mp_sb #(.BUS_DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD_PORTS(NRD),
                    .NUM_WR_PORTS(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .dump_start(dump_start), .dump_valid(dump_valid_nb), .dump_ready(dump_ready),
        .dump_idx(dump_idx_nb), .dump_data(dump_data_nb), .dump_done(dump_done_nb));

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    int            m_state;   // 0 idle, 1 streaming, 2 done pulse
    int            m_idx;

    typedef struct packed {
        logic [NRD*DW-1:0] rd;
        logic [NRD*DW-1:0] rdnb;
        logic [NRD-1:0]    busy;
        logic              valid;
        logic              done;
        logic [AW-1:0]     idx;
        logic [DW-1:0]     ddata;
        logic [DW-1:0]     ddata_nb;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_busy  = '0;
        m_state = 0;
        m_idx   = 0;
    endtask

    // Value seen this cycle at address a: register 0 is zero, otherwise the
    // last (highest-index) port writing a this cycle, otherwise stored value.
    function automatic logic [DW-1:0] fwd_val(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && (int'(wr_addr[p*AW +: AW]) == a)) v = wr_data[p*DW +: DW];
        return v;
    endfunction

    // One clock cycle: publish expectations for the inputs now applied,
    // advance the model at the edge, then return 1ns after the edge.
    task automatic cyc();
        exp_t e;
        int   a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            e.rd[i*DW +: DW]   = fwd_val(a);
            e.rdnb[i*DW +: DW] = m_regs[a];
            e.busy[i]          = m_busy[a];
        end
        e.valid    = (m_state == 1);
        e.done     = (m_state == 2);
        e.idx      = AW'(m_idx);
        e.ddata    = fwd_val(m_idx);
        e.ddata_nb = m_regs[m_idx];
        exp_q.push_back(e);
        if (m_state == 1 && dump_ready) beat_q.push_back({AW'(m_idx), fwd_val(m_idx)});
        @(posedge clk);
        if (!reset) begin
            for (int p = 0; p < NWR; p++) begin
                a = int'(wr_addr[p*AW +: AW]);
                if (wr_en[p] && a != 0) begin
                    m_regs[a] = wr_data[p*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) m_busy[alloc_addr] = 1'b1;
            case (m_state)
                0: if (dump_start) begin m_state = 1; m_idx = 0; end
                1: if (dump_ready) begin
                       if (m_idx == NR - 1) m_state = 2;
                       else m_idx++;
                   end
                default: begin m_state = 0; m_idx = 0; end
            endcase
        end
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t  e;
        beat_t b;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NRD; i++) begin
                chk("rd_data",    rd_data[i*DW +: DW],    e.rd[i*DW +: DW]);
                chk("rd_data_nb", rd_data_nb[i*DW +: DW], e.rdnb[i*DW +: DW]);
                chk("rd_busy",    DW'(rd_busy[i]),        DW'(e.busy[i]));
            end
            chk("dump_valid", DW'(dump_valid), DW'(e.valid));
            chk("dump_done",  DW'(dump_done),  DW'(e.done));
            if (e.valid) begin
                chk("dump_idx",     DW'(dump_idx), DW'(e.idx));
                chk("dump_data",    dump_data,     e.ddata);
                chk("dump_data_nb", dump_data_nb,  e.ddata_nb);
            end
        end
        if (dump_valid && dump_ready) begin
            if (beat_q.size() == 0) begin
                chk("beat_unexpected", DW'(1), DW'(0));
            end else begin
                b = beat_q.pop_front();
                chk("beat_idx",  DW'(dump_idx), DW'(b.idx));
                chk("beat_data", dump_data,     b.data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        wr_en      = '0;
        alloc_en   = 1'b0;
        dump_start = 1'b0;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, NR - 1));
        for (int p = 0; p < NWR; p++) begin
            wr_en[p]            = ($urandom_range(0, 2) != 0);
            // Narrow address range half the time to provoke port collisions.
            wr_addr[p*AW +: AW] = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : NR - 1));
            wr_data[p*DW +: DW] = {$urandom(), $urandom()};
        end
        alloc_en   = ($urandom_range(0, 3) == 0);
        alloc_addr = AW'($urandom_range(0, NR - 1));
        dump_start = ($urandom_range(0, 15) == 0);
        dump_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_clear();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        reset = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; dump_start = 1'b0; dump_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        cyc(); cyc();
        reset = 1'b0;

        // 1: activity, reset mid-run, then sweep all addresses for zeros
        repeat (8) begin rand_inputs(); cyc(); end
        do_reset();
        dump_ready = 1'b0;
        for (int i = 0; i < NR / 2; i++) begin
            rd_addr = {AW'(2*i + 1), AW'(2*i)};
            cyc();
        end

        // 2: basic write/read, and register 0 ignores writes
        wr_en = 2'b01; wr_addr[0 +: AW] = AW'(5); wr_data[0 +: DW] = 64'hDEAD;
        rd_addr = {AW'(5), AW'(5)};
        cyc(); idle(); cyc();
        wr_en = 2'b01; wr_addr[0 +: AW] = '0; wr_data[0 +: DW] = 64'h1234;
        rd_addr = '0;
        cyc(); idle(); cyc();

        // 3: two ports write x7 in the same cycle; port 1 wins
        wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {64'd2, 64'd1};
        rd_addr = {AW'(7), AW'(7)};
        cyc(); idle(); cyc();

        // 4: scoreboard alloc / write interaction on x3
        rd_addr = {AW'(3), AW'(3)};
        alloc_en = 1'b1; alloc_addr = AW'(3);
        cyc();
        wr_en = 2'b01; wr_addr[0 +: AW] = AW'(3); wr_data[0 +: DW] = 64'd9;
        cyc();
        alloc_en = 1'b0;
        cyc(); idle(); cyc();

        // 5: preload x1..x31 = 3*i, dump with ready toggling, extra start ignored
        for (int i = 1; i < NR; i += 2) begin
            wr_en = (i + 1 < NR) ? 2'b11 : 2'b01;
            wr_addr = {AW'(i + 1), AW'(i)};
            wr_data = {64'(3 * (i + 1)), 64'(3 * i)};
            cyc();
        end
        idle();
        rd_addr = {AW'(31), AW'(1)};
        dump_start = 1'b1; dump_ready = 1'b0;
        cyc();
        dump_start = 1'b0;
        k = 0;
        while (m_state != 0 && k < 200) begin
            dump_ready = k[0];
            dump_start = (k == 5);
            cyc();
            k++;
        end
        dump_start = 1'b0;
        cyc(); cyc();

        // 6: reset at beat 10 aborts the dump; a new dump restarts at idx 0
        dump_start = 1'b1; dump_ready = 1'b1;
        cyc();
        dump_start = 1'b0;
        k = 0;
        while (m_idx < 10 && k < 50) begin cyc(); k++; end
        do_reset();
        cyc(); cyc();
        dump_start = 1'b1;
        cyc();
        dump_start = 1'b0;
        k = 0;
        while (m_state != 0 && k < 300) begin
            dump_ready = ($urandom_range(0, 1) != 0);
            cyc();
            k++;
        end

        // randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rand_inputs();
                cyc();
            end
        end
        idle(); dump_ready = 1'b1;
        repeat (40) cyc();

        @(negedge clk); #1;
        chk("exp_q_drained",  DW'(exp_q.size()),  DW'(0));
        chk("beat_q_drained", DW'(beat_q.size()), DW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file with a per-register busy scoreboard and a handshaked register-dump engine.
- Sits between decode (read ports, destination allocation) and writeback (write ports) in the pipelined core.
- Replaces the fixed 2-read/1-write file and its simulation-only register print with a synthesizable, streamable dump.

Parameters:
- BUS_DATA_WIDTH, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers (power of two, >= 2).
- NUM_RD_PORTS, 2, number of read ports.
- NUM_WR_PORTS, 2, number of write ports.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = none.
- Localparam AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD_PORTS*AW  packed read addresses; port i occupies [i*AW +: AW].
- rd_data  out  NUM_RD_PORTS*BUS_DATA_WIDTH  packed read data.
- rd_busy  out  NUM_RD_PORTS  scoreboard busy bit of each read address.
- wr_en  in  NUM_WR_PORTS  per-port write enable.
- wr_addr  in  NUM_WR_PORTS*AW  packed write addresses.
- wr_data  in  NUM_WR_PORTS*BUS_DATA_WIDTH  packed write data.
- alloc_en  in  1  mark a destination register busy.
- alloc_addr  in  AW  destination register to mark.
- dump_start  in  1  start a dump (honoured only in IDLE).
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  AW  index of the current beat.
- dump_data  out  BUS_DATA_WIDTH  content of register dump_idx.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, active-high): all registers 0, all busy bits 0, FSM IDLE, dump_valid/dump_done/dump_idx 0. Reset asserted mid-dump aborts the dump; no dump_done.
- Register 0 is hardwired to zero: reads return 0, rd_busy 0, writes and allocs to it are ignored.
- Reads are combinational, zero latency. rd_data = stored value, or with BYPASS=1 the wr_data of the highest-index port writing that nonzero address this cycle.
- Writes commit on posedge clk. When several ports target the same address, the highest-index port wins.
- Scoreboard:
  - alloc_en sets busy[alloc_addr] at the clock edge.
  - Any committed write clears busy[wr_addr].
  - Alloc and write to the same address in the same cycle: busy ends at 1 (new producer wins).
  - rd_busy reflects registered busy only. No bypass of a same-cycle clear or set.
- Dump FSM:
  - IDLE -> DUMP on dump_start, with idx = 0.
  - DUMP: dump_valid = 1, dump_data = current register[idx], combinational including bypass.
    - On dump_valid && dump_ready with idx < NUM_REGS-1: idx increments.
    - On dump_valid && dump_ready with idx = NUM_REGS-1: -> DONE.
    - If dump_ready is low: idx and valid hold; dump_data may change if the register is written.
  - DONE: dump_done = 1 for exactly one cycle, dump_valid = 0, then -> IDLE with idx reset to 0.
  - dump_start in DUMP or DONE is ignored.
  - Register writes and allocs continue normally during a dump.
- idx arithmetic is AW bits wide. The terminal compare against NUM_REGS-1 guarantees no wrap.

Decomposition:
- Shared package regfile_pkg:
  - dump_state_t enum {DUMP_IDLE, DUMP_RUN, DUMP_DONE}.
  - Default width and count constants.
  - Function for the bypass-priority select.
- One sub-module, regfile_dump_fsm: FSM, idx counter, valid/done generation. It drives idx to the parent's read mux.

Test Plan:
1. Assert reset mid-run, release -> every rd_data = 0, rd_busy = 0, dump_valid = 0, dump_done = 0.
2. Write port0 x5 = 0xDEAD, next cycle read x5 -> 0xDEAD. Write x0 = 0x1234, read x0 -> 0.
3. Same cycle: port0 writes x7 = 1, port1 writes x7 = 2, read port on x7 -> bypassed value 2 that cycle; next cycle stored x7 = 2. Repeat with BYPASS=0 -> old value that cycle.
4. Alloc x3 -> rd_busy 1 next cycle. Alloc x3 again and write x3 = 9 in the same cycle -> busy stays 1. Write x3 alone -> busy 0 next cycle, x3 = 9.
5. Preload x1..x31 = index*3, dump_start, dump_ready toggling 1/0 -> beats idx 0..31 with data 0, 3, ..., 93; each beat held while ready = 0; dump_done pulses one cycle after beat 31; a second dump_start during DUMP is ignored.
6. Reset asserted at beat 10 of a dump -> dump_valid 0 immediately, no dump_done, FSM IDLE. A new dump_start restarts at idx 0.
